// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: shares the instruction memory port between program load and fetch.
// It also owns the PC and drives the IF/ID outputs.
module imem_fetch_ctrl #(
   parameter int          DEPTH    = 16,
   parameter logic [15:0] START_PC = 16'h0000,
   parameter logic [3:0]  HALT_OP  = 4'hF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [15:0] ld_addr,
   input  logic [15:0] ld_data,
   input  logic        start,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_we,
   input  logic [15:0] mem_rdata,
   output logic        if_valid,
   output logic [15:0] if_instr,
   output logic [15:0] if_pc,
   output logic        halted,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, RUN, HALT, ERR} state_t;
   localparam logic [16:0] LIMIT = 17'(2 * DEPTH);
   state_t state, state_nx;
   logic [15:0] pc, pc_nx, instr_nx, ipc_nx;
   logic v_nx, halted_nx, err_nx;
   logic ld_ok, ld_fire, tgt_ok, is_halt, fetch_last;
   function automatic logic addr_ok(input logic [15:0] a);
      return !a[0] && ({1'b0, a} < LIMIT);
   endfunction
   assign ld_ok      = addr_ok(ld_addr);
   assign tgt_ok     = addr_ok(redirect_pc);
   assign ld_fire    = (state == IDLE) && ld_valid && ld_ready;
   assign mem_we     = ld_fire && ld_ok;
   assign mem_addr   = (state == IDLE) ? ld_addr : pc;
   assign mem_wdata  = ld_data;
   assign is_halt    = mem_rdata[15:12] == HALT_OP;
   assign fetch_last = ({1'b0, pc} + 17'd2) >= LIMIT;
   always_comb begin
      state_nx  = state;
      pc_nx     = pc;
      instr_nx  = if_instr;
      ipc_nx    = if_pc;
      v_nx      = if_valid;
      halted_nx = halted;
      err_nx    = err;
      case (state)
         IDLE: begin
            if (ld_fire && !ld_ok) err_nx = 1'b1;
            if (start) begin
               state_nx = RUN;
               pc_nx    = START_PC;
            end
         end
         RUN: begin
            if (redirect) begin
               v_nx = 1'b0;
               if (tgt_ok) pc_nx = redirect_pc;
               else begin
                  state_nx = ERR;
                  err_nx   = 1'b1;
               end
            end else if (!stall) begin
               // a non-halt word in the last slot would need pc to run past the end
               if (!is_halt && fetch_last) begin
                  state_nx = ERR;
                  err_nx   = 1'b1;
                  v_nx     = 1'b0;
               end else begin
                  instr_nx = mem_rdata;
                  ipc_nx   = pc;
                  v_nx     = 1'b1;
                  if (is_halt) begin
                     state_nx  = HALT;
                     halted_nx = 1'b1;
                  end else pc_nx = pc + 16'd2;
               end
            end
         end
         HALT: begin
            if (start) begin
               state_nx  = RUN;
               pc_nx     = START_PC;
               halted_nx = 1'b0;
               v_nx      = 1'b0;
            end else if (redirect) begin
               halted_nx = 1'b0;
               v_nx      = 1'b0;
               if (tgt_ok) begin
                  state_nx = RUN;
                  pc_nx    = redirect_pc;
               end else begin
                  state_nx = ERR;
                  err_nx   = 1'b1;
               end
            end else if (!stall) v_nx = 1'b0;
         end
         ERR: begin
            v_nx = 1'b0;
            if (start) begin
               state_nx = RUN;
               pc_nx    = START_PC;
            end
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         pc       <= START_PC;
         if_valid <= 1'b0;
         if_instr <= 16'h0000;
         if_pc    <= 16'h0000;
         halted   <= 1'b0;
         err      <= 1'b0;
         ld_ready <= 1'b0;
      end else begin
         state    <= state_nx;
         pc       <= pc_nx;
         if_valid <= v_nx;
         if_instr <= instr_nx;
         if_pc    <= ipc_nx;
         halted   <= halted_nx;
         err      <= err_nx;
         ld_ready <= state_nx == IDLE;
      end
   end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed scenarios plus a randomized run against a behavioural model.
module tb_imem_fetch_ctrl;
   localparam int DEPTH = 16;
   localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_ERR = 3;
   logic clk = 1'b0, rst = 1'b0;
   logic ld_valid = 1'b0, start = 1'b0, stall = 1'b0, redirect = 1'b0;
   logic [15:0] ld_addr = '0, ld_data = '0, redirect_pc = '0;
   logic ld_ready, mem_we, if_valid, halted, err;
   logic [15:0] mem_addr, mem_wdata, mem_rdata, if_instr, if_pc;
   logic [15:0] mem [DEPTH];
   int errors = 0, checks = 0;
   int m_mode;
   logic [15:0] m_pc, m_instr, m_ipc;
   logic m_v, m_halted, m_err, m_ldr;
   logic [15:0] m_mem [DEPTH];

   imem_fetch_ctrl #(.DEPTH(DEPTH), .START_PC(16'h0000), .HALT_OP(4'hF)) dut (
      .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
      .ld_data(ld_data), .start(start), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .halted(halted), .err(err));

   always #5 clk = ~clk;
   assign mem_rdata = (mem_addr < 16'(2 * DEPTH)) ? mem[mem_addr[4:1]] : 16'h0000;
   always @(posedge clk) if (mem_we && mem_addr < 16'(2 * DEPTH)) mem[mem_addr[4:1]] <= mem_wdata;

   function automatic logic ok(input logic [15:0] a);
      return (a % 2 == 0) && (int'(a) < 2 * DEPTH);
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE; m_pc = 16'h0; m_instr = 16'h0; m_ipc = 16'h0;
      m_v = 1'b0; m_halted = 1'b0; m_err = 1'b0; m_ldr = 1'b0;
   endtask

   // Advance one clock; the model consumes the inputs as they stand just before the edge.
   task automatic tick();
      logic [15:0] w;
      if (rst) begin
         case (m_mode)
            M_IDLE: begin
               if (ld_valid && m_ldr) begin
                  if (ok(ld_addr)) m_mem[ld_addr / 2] = ld_data; else m_err = 1'b1;
               end
               if (start) begin m_mode = M_RUN; m_pc = 16'h0; end
            end
            M_RUN: begin
               if (redirect) begin
                  m_v = 1'b0;
                  if (ok(redirect_pc)) m_pc = redirect_pc;
                  else begin m_mode = M_ERR; m_err = 1'b1; end
               end else if (!stall) begin
                  w = m_mem[m_pc / 2];
                  if (w[15:12] == 4'hF) begin
                     m_instr = w; m_ipc = m_pc; m_v = 1'b1; m_mode = M_HALT; m_halted = 1'b1;
                  end else if (int'(m_pc) + 2 >= 2 * DEPTH) begin
                     m_mode = M_ERR; m_err = 1'b1; m_v = 1'b0;
                  end else begin
                     m_instr = w; m_ipc = m_pc; m_v = 1'b1; m_pc = m_pc + 16'd2;
                  end
               end
            end
            M_HALT: begin
               if (start) begin m_mode = M_RUN; m_pc = 16'h0; m_halted = 1'b0; m_v = 1'b0; end
               else if (redirect) begin
                  m_halted = 1'b0; m_v = 1'b0;
                  if (ok(redirect_pc)) begin m_mode = M_RUN; m_pc = redirect_pc; end
                  else begin m_mode = M_ERR; m_err = 1'b1; end
               end else if (!stall) m_v = 1'b0;
            end
            default: begin
               m_v = 1'b0;
               if (start) begin m_mode = M_RUN; m_pc = 16'h0; end
            end
         endcase
         m_ldr = (m_mode == M_IDLE);
      end
      @(posedge clk); #1;
   endtask

   task automatic apply_reset();
      rst = 1'b0; ld_valid = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0;
      model_reset();
      #7;
      @(negedge clk); rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      #12;
      checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got=%b want=0", ld_ready); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid got=%b want=0", if_valid); end
      checks++; if (if_instr !== 16'h0) begin errors++; $display("FAIL reset_if_instr got=%h want=0000", if_instr); end
      checks++; if (if_pc !== 16'h0) begin errors++; $display("FAIL reset_if_pc got=%h want=0000", if_pc); end
      checks++; if (halted !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b want=00", halted, err); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
      model_reset();
      @(negedge clk); rst = 1'b1;
      tick();
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ld_ready got=%b want=1", ld_ready); end
   endtask

   task automatic test_load_run();
      logic [15:0] la [6] = '{16'h0, 16'h2, 16'h4, 16'h6, 16'h8, 16'hA};
      logic [15:0] ld [6] = '{16'h1010, 16'h1010, 16'h1010, 16'h1011, 16'hF000, 16'h1010};
      for (int i = 0; i < 6; i++) begin
         ld_valid = 1'b1; ld_addr = la[i]; ld_data = ld[i]; #1;
         checks++; if (mem_we !== 1'b1 || mem_addr !== la[i] || mem_wdata !== ld[i]) begin
            errors++; $display("FAIL load_write got we=%b addr=%h data=%h want we=1 addr=%h data=%h", mem_we, mem_addr, mem_wdata, la[i], ld[i]);
         end
         tick();
      end
      ld_valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
      checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL run_ld_ready got=%b want=0", ld_ready); end
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (if_valid !== 1'b1 || if_pc !== 16'(2 * k) || if_instr !== (k == 3 ? 16'h1011 : 16'h1010)) begin
            errors++; $display("FAIL run_fetch%0d got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", k, if_valid, if_pc, if_instr, 16'(2 * k), (k == 3 ? 16'h1011 : 16'h1010));
         end
      end
   endtask

   task automatic test_stall();
      redirect = 1'b1; redirect_pc = 16'h2; tick(); redirect = 1'b0; tick();
      checks++; if (if_pc !== 16'h2 || if_valid !== 1'b1) begin errors++; $display("FAIL stall_setup got pc=%h v=%b want pc=0002 v=1", if_pc, if_valid); end
      stall = 1'b1;
      repeat (2) begin
         tick();
         checks++; if (if_pc !== 16'h2 || if_instr !== 16'h1010 || if_valid !== 1'b1 || mem_addr !== 16'h4) begin
            errors++; $display("FAIL stall_hold got pc=%h instr=%h v=%b mem_addr=%h want 0002 1010 1 0004", if_pc, if_instr, if_valid, mem_addr);
         end
      end
      stall = 1'b0; tick();
      checks++; if (if_pc !== 16'h4 || if_valid !== 1'b1) begin errors++; $display("FAIL stall_resume got pc=%h v=%b want pc=0004 v=1", if_pc, if_valid); end
   endtask

   task automatic test_redirect_stall();
      stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h000A; tick();
      stall = 1'b0; redirect = 1'b0;
      checks++; if (if_valid !== 1'b0 || mem_addr !== 16'h000A) begin errors++; $display("FAIL redirect_bubble got v=%b mem_addr=%h want v=0 mem_addr=000a", if_valid, mem_addr); end
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 16'h000A || if_instr !== 16'h1010) begin
         errors++; $display("FAIL redirect_target got v=%b pc=%h instr=%h want 1 000a 1010", if_valid, if_pc, if_instr);
      end
   endtask

   task automatic test_halt();
      redirect = 1'b1; redirect_pc = 16'h8; tick(); redirect = 1'b0; tick();
      checks++; if (if_instr !== 16'hF000 || if_valid !== 1'b1 || halted !== 1'b1 || if_pc !== 16'h8) begin
         errors++; $display("FAIL halt_present got instr=%h v=%b halted=%b pc=%h want f000 1 1 0008", if_instr, if_valid, halted, if_pc);
      end
      tick();
      checks++; if (if_valid !== 1'b0 || halted !== 1'b1 || mem_addr !== 16'h8) begin
         errors++; $display("FAIL halt_frozen got v=%b halted=%b mem_addr=%h want 0 1 0008", if_valid, halted, mem_addr);
      end
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_restart_flag got=%b want=0", halted); end
      tick();
      checks++; if (if_pc !== 16'h0 || if_valid !== 1'b1 || if_instr !== 16'h1010) begin
         errors++; $display("FAIL halt_restart_fetch got pc=%h v=%b instr=%h want 0000 1 1010", if_pc, if_valid, if_instr);
      end
   endtask

   task automatic test_errors();
      apply_reset();
      ld_valid = 1'b1; ld_addr = 16'h3; ld_data = 16'hBEEF; #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL err_odd_we got=%b want=0", mem_we); end
      tick(); ld_valid = 1'b0;
      checks++; if (err !== 1'b1 || ld_ready !== 1'b1) begin errors++; $display("FAIL err_odd_flag got err=%b ld_ready=%b want 1 1", err, ld_ready); end
      start = 1'b1; tick(); start = 1'b0;
      redirect = 1'b1; redirect_pc = 16'h0020; tick(); redirect = 1'b0;
      checks++; if (if_valid !== 1'b0 || err !== 1'b1) begin errors++; $display("FAIL err_range got v=%b err=%b want 0 1", if_valid, err); end
      redirect = 1'b1; redirect_pc = 16'h2; tick(); redirect = 1'b0; tick();
      checks++; if (if_valid !== 1'b0 || mem_addr !== 16'h0) begin errors++; $display("FAIL err_frozen got v=%b mem_addr=%h want 0 0000", if_valid, mem_addr); end
      start = 1'b1; tick(); start = 1'b0; tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0 || err !== 1'b1) begin
         errors++; $display("FAIL err_restart got v=%b pc=%h err=%b want 1 0000 1", if_valid, if_pc, err);
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      start = 1'b1; tick(); start = 1'b0; tick(); tick();
      checks++; if (mem_addr !== 16'h4 || if_pc !== 16'h2) begin errors++; $display("FAIL areset_setup got mem_addr=%h if_pc=%h want 0004 0002", mem_addr, if_pc); end
      #2; ld_valid = 1'b1; ld_addr = 16'h0; ld_data = 16'hDEAD; rst = 1'b0; #1;
      model_reset();
      checks++; if (if_valid !== 1'b0 || if_pc !== 16'h0 || if_instr !== 16'h0 || halted !== 1'b0 || err !== 1'b0 || ld_ready !== 1'b0 || mem_we !== 1'b0) begin
         errors++; $display("FAIL areset_outputs got v=%b pc=%h instr=%h h=%b e=%b rdy=%b we=%b want all zero", if_valid, if_pc, if_instr, halted, err, ld_ready, mem_we);
      end
      ld_valid = 1'b0;
      @(negedge clk); rst = 1'b1; tick();
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL areset_release got ld_ready=%b want 1", ld_ready); end
   endtask

   task automatic test_random();
      logic exp_we;
      logic [15:0] exp_addr;
      apply_reset();
      for (int c = 0; c < 500; c++) begin
         if (c < 60) begin
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_addr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : {11'h0, 4'($urandom_range(0, DEPTH - 1)), 1'b0};
            ld_data = {($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14)), 12'($urandom)};
            start = 1'b0;
         end else begin
            ld_valid = $urandom_range(0, 1);
            ld_addr = 16'($urandom);
            start = (c == 60) || ($urandom_range(0, 29) == 0);
         end
         stall = ($urandom_range(0, 9) < 3);
         redirect = ($urandom_range(0, 9) == 0);
         redirect_pc = ($urandom_range(0, 19) == 0) ? 16'h0021 : {11'h0, 4'($urandom_range(0, DEPTH - 1)), 1'b0};
         #1;
         exp_we = (m_mode == M_IDLE) && m_ldr && ld_valid && ok(ld_addr);
         exp_addr = (m_mode == M_IDLE) ? ld_addr : m_pc;
         checks++; if (mem_we !== exp_we || mem_addr !== exp_addr) begin
            errors++; $display("FAIL rand_mem c=%0d got we=%b addr=%h want we=%b addr=%h", c, mem_we, mem_addr, exp_we, exp_addr);
         end
         tick();
         checks++; if (if_valid !== m_v || halted !== m_halted || err !== m_err || ld_ready !== m_ldr) begin
            errors++; $display("FAIL rand_flags c=%0d got v=%b h=%b e=%b rdy=%b want v=%b h=%b e=%b rdy=%b", c, if_valid, halted, err, ld_ready, m_v, m_halted, m_err, m_ldr);
         end
         if (m_v) begin
            checks++; if (if_pc !== m_ipc || if_instr !== m_instr) begin
               errors++; $display("FAIL rand_fetch c=%0d got pc=%h instr=%h want pc=%h instr=%h", c, if_pc, if_instr, m_ipc, m_instr);
            end
         end
      end
      ld_valid = 1'b0; start = 1'b0; stall = 1'b0; redirect = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin mem[i] = 16'h0; m_mem[i] = 16'h0; end
      model_reset();
      test_reset();
      test_load_run();
      test_stall();
      test_redirect_stall();
      test_halt();
      test_errors();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequencer for the single-port instruction memory (16-bit words at even byte addresses, combinational read).
- Arbitrates the memory port between a program-load port (writes) and the IF stage fetch (reads).
- Owns the PC and presents fetched instructions to the IF/ID register.
- Handles stall, branch/jump redirect, halt and out-of-range errors.

Parameters:
- DEPTH, 16, number of 16-bit instruction words; valid byte addresses are 0 to 2*DEPTH-2, even only.
- START_PC, 16'h0000, PC loaded on start.
- HALT_OP, 4'hF, opcode (instr[15:12]) that stops fetch.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ld_valid  in  1  load word offered.
- ld_ready  out  1  controller accepts load word this cycle.
- ld_addr  in  16  byte address of load word.
- ld_data  in  16  instruction word to write.
- start  in  1  begin fetch at START_PC.
- stall  in  1  hazard stall from ID; hold PC and IF outputs.
- redirect  in  1  taken branch/jump from EX.
- redirect_pc  in  16  target byte address.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  16  memory read data (combinational).
- if_valid  out  1  if_instr/if_pc hold a real instruction.
- if_instr  out  16  fetched instruction.
- if_pc  out  16  address of if_instr.
- halted  out  1  fetch stopped on HALT_OP.
- err  out  1  sticky error: odd or out-of-range address.

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=START_PC, if_valid=0, if_instr=0, if_pc=0, halted=0, err=0, ld_ready=0. Memory contents untouched.
- States: IDLE, RUN, HALT, ERR.
- IDLE:
  - ld_ready=1 (registered; 1 in first cycle after reset release).
  - Load handshake: accepted when ld_valid & ld_ready. Then mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data in the same cycle.
  - Odd or out-of-range ld_addr: write suppressed (mem_we=0), err set, state stays IDLE.
  - start=1: state→RUN, pc=START_PC, ld_ready=0 next cycle. If ld_valid and start coincide, the write completes first, then RUN.
- RUN (mem_we=0, mem_addr=pc):
  - Priority: redirect > stall > normal.
  - redirect=1 (even, in-range target): pc←redirect_pc, if_valid←0 (one-cycle bubble). Applies even with stall=1.
  - stall=1, no redirect: pc, if_valid, if_instr and if_pc hold.
  - normal: if_instr←mem_rdata, if_pc←pc, if_valid←1, pc←pc+2. Latency: instruction at address A appears on if_* one cycle after pc=A.
  - mem_rdata[15:12]==HALT_OP on a normal fetch: the HALT word is still presented with if_valid=1, pc does not advance, state→HALT.
  - Odd or out-of-range redirect target, or pc+2 reaching 2*DEPTH: state→ERR, err=1, if_valid←0. No wrap-around.
  - start ignored; ld_ready=0.
- HALT:
  - halted=1; if_valid←0 after the HALT word leaves (first non-stalled cycle).
  - redirect is honoured (returns to RUN, halted←0).
  - start restarts at START_PC.
- ERR: if_valid=0, fetch frozen. Only start (→RUN, err stays sticky) or reset leaves it.
- Reset mid-load or mid-fetch: immediate return to IDLE, no partial write (mem_we is combinational from the handshake and deasserts with reset).
- All outputs registered except mem_addr, mem_we and mem_wdata, which are combinational from state/pc/ld_*.

Test Plan:
- Load then run: load 16'h1010 at addresses 0/2/4 and 16'h1011 at 6 (4 handshakes, mem_we pulses), then start. Required: if_instr 1010,1010,1010,1011 on successive cycles; if_pc 0,2,4,6; if_valid=1.
- Stall: assert stall for 2 cycles while if_pc=2. Required: if_pc=2 and if_instr=1010 held; pc stays 4; resumes with if_pc=4.
- Redirect vs stall: with stall=1 and redirect=1, redirect_pc=16'h000A, where word 10 holds 16'h1010. Required: one if_valid=0 bubble, then if_pc=000A, if_instr=1010.
- Halt: word 8 = 16'hF000. Required: if_instr=F000 presented once, halted=1, pc frozen at 8; start returns to if_pc=0.
- Errors: load at ld_addr=3 → no mem_we, err=1. Redirect to 16'h0020 with DEPTH=16 → state ERR, if_valid=0.
- Async reset while fetching at pc=4 → all outputs at reset values within the same cycle; ld_ready=1 after reset release.
